// File: rtl/alu_pkg.sv
// Shared ALU definitions: the control code type, opcode constants, the
// highest legal opcode and the arbiter/sequencer state encoding.
package alu_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD  = 4'b0000;
  localparam alu_ctrl_t ALU_SUB  = 4'b0001;
  localparam alu_ctrl_t ALU_AND  = 4'b0010;
  localparam alu_ctrl_t ALU_OR   = 4'b0011;
  localparam alu_ctrl_t ALU_XOR  = 4'b0100;
  localparam alu_ctrl_t ALU_SLL  = 4'b0101;
  localparam alu_ctrl_t ALU_SRL  = 4'b0110;
  localparam alu_ctrl_t ALU_SRA  = 4'b0111;
  localparam alu_ctrl_t ALU_SLT  = 4'b1000;
  localparam alu_ctrl_t ALU_SLTU = 4'b1001;

  localparam alu_ctrl_t ALU_CTRL_MAX = 4'b1001;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } arb_state_t;

  function automatic logic ctrl_is_legal(input alu_ctrl_t ctrl);
    return ctrl <= ALU_CTRL_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by the arbiter.
// Ports:
//   op1_i, op2_i : operands (WIDTH bits)
//   ctrl_i       : opcode (alu_ctrl_t)
//   result_o     : result (WIDTH bits)
//   flags_o      : {N, Z, C, V}; all zero for an undefined opcode.
// C is the carry out for ADD and the borrow (op1 < op2 unsigned) for SUB.
// V is signed overflow for ADD/SUB. Shifts use the low log2(WIDTH) bits of op2.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  alu_ctrl_t        ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   shamt;
  logic             carry;
  logic             ovf;
  logic             legal;

  always_comb begin
    add_w    = {1'b0, op1_i} + {1'b0, op2_i};
    sub_w    = {1'b0, op1_i} - {1'b0, op2_i};
    shamt    = op2_i[SHW-1:0];
    result_o = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    legal    = 1'b1;
    case (ctrl_i)
      ALU_ADD: begin
        result_o = add_w[WIDTH-1:0];
        carry    = add_w[WIDTH];
        ovf      = (op1_i[WIDTH-1] == op2_i[WIDTH-1]) &&
                   (add_w[WIDTH-1] != op1_i[WIDTH-1]);
      end
      ALU_SUB: begin
        result_o = sub_w[WIDTH-1:0];
        carry    = sub_w[WIDTH];
        ovf      = (op1_i[WIDTH-1] != op2_i[WIDTH-1]) &&
                   (sub_w[WIDTH-1] != op1_i[WIDTH-1]);
      end
      ALU_AND:  result_o = op1_i & op2_i;
      ALU_OR:   result_o = op1_i | op2_i;
      ALU_XOR:  result_o = op1_i ^ op2_i;
      ALU_SLL:  result_o = op1_i << shamt;
      ALU_SRL:  result_o = op1_i >> shamt;
      ALU_SRA:  result_o = $signed(op1_i) >>> shamt;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(op1_i) < $signed(op2_i))};
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, (op1_i < op2_i)};
      default:  legal    = 1'b0;
    endcase
    flags_o = legal ? {result_o[WIDTH-1], (result_o == '0), carry, ovf} : '0;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i  : request vector (NREQ bits)
//   last_i : index of the most recent grant; the search starts one above it
//   gnt_o  : one-hot grant (all zero when no request is present)
//   idx_o  : encoded index of the granted requester
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic           found;
  logic [IDW-1:0] cand;

  // Visit last+1, last+2, ... last+NREQ (mod NREQ); the first hit wins,
  // so the previous winner is considered last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(last_i) + i) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NREQ requesters. IDLE arbitrates round-robin and
// latches the winner's operands, EXEC runs the ALU and registers the
// response, RESP presents it until the consumer accepts it.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake; req_ready is one-hot
//   req_op1/req_op2      : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ctrl             : packed opcodes, requester i at [i*4 +: 4]
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id               : owner of the response
//   rsp_result/rsp_flags : registered ALU outputs (zero on error)
//   rsp_err              : opcode outside the ALU's defined set
//   busy                 : FSM not in IDLE
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned NREQ  = 4,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_op1,
  input  logic [NREQ*WIDTH-1:0] req_op2,
  input  logic [NREQ*4-1:0]     req_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_err,
  output logic                  busy
);

  arb_state_t       state_q;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   op_id_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  alu_ctrl_t        ctrl_q;

  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic [3:0]       rsp_flags_q;
  logic             rsp_err_q;

  logic [WIDTH-1:0] rsp_result_d;
  logic [3:0]       rsp_flags_d;
  logic             rsp_err_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] sel_op1;
  logic [WIDTH-1:0] sel_op2;
  alu_ctrl_t        sel_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req_i  (req_valid),
    .last_i (last_grant_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op1_i    (op1_q),
    .op2_i    (op2_q),
    .ctrl_i   (ctrl_q),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  // One-hot mux of the winner's request fields.
  always_comb begin
    sel_op1  = '0;
    sel_op2  = '0;
    sel_ctrl = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op1  = req_op1[i*WIDTH +: WIDTH];
        sel_op2  = req_op2[i*WIDTH +: WIDTH];
        sel_ctrl = req_ctrl[i*4 +: 4];
      end
    end
  end

  always_comb begin
    rsp_err_d    = !ctrl_is_legal(ctrl_q);
    rsp_result_d = rsp_err_d ? '0 : alu_result;
    rsp_flags_d  = rsp_err_d ? '0 : alu_flags;
  end

  // Gated by reset so no grant is shown while reset is held.
  assign req_ready = (state_q == IDLE && reset) ? gnt : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      op_id_q      <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            op1_q        <= sel_op1;
            op2_q        <= sel_op2;
            ctrl_q       <= sel_ctrl;
            op_id_q      <= gnt_idx;
            last_grant_q <= gnt_idx;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= rsp_result_d;
          rsp_flags_q  <= rsp_flags_d;
          rsp_err_q    <= rsp_err_d;
          rsp_id_q     <= op_id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table plus hand-written back-pressure,
// reset-during-EXEC and saturation sequences. Expected responses are queued
// when requests are driven and compared when the response handshakes.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_op1;
  logic [127:0] req_op2;
  logic [15:0]  req_ctrl;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic         busy;

  always #5 clk = ~clk;

  alu_arbiter #(
    .WIDTH (32),
    .NREQ  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected event, expected handshake (t=%0t)", name, $time);
  endtask

  // Reference ALU: returns {err, flags[3:0], result[31:0]}.
  function automatic logic [36:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [32:0] w;
    logic [31:0] r;
    logic        cy;
    logic        v;
    r  = 32'd0;
    cy = 1'b0;
    v  = 1'b0;
    if (c > 4'd9) return {1'b1, 4'b0000, 32'd0};
    case (c)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; cy = (a < b);
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $signed(a) >>> b[4:0];
      4'd8: r = {31'd0, ($signed(a) < $signed(b))};
      default: r = {31'd0, (a < b)};
    endcase
    return {1'b0, r[31], (r == 32'd0), cy, v, r};
  endfunction

  function automatic vec_t mk(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] c, input logic [31:0] res,
                              input logic [3:0] fl, input logic err);
    vec_t v;
    v.id = id; v.op1 = a; v.op2 = b; v.ctrl = c; v.res = res; v.flags = fl; v.err = err;
    return v;
  endfunction

  function automatic exp_t exp_of(input logic [1:0] id, input logic [31:0] a,
                                  input logic [31:0] b, input logic [3:0] c);
    exp_t e;
    logic [36:0] r;
    r = ref_alu(a, b, c);
    e.id = id; e.res = r[31:0]; e.flags = r[35:32]; e.err = r[36];
    return e;
  endfunction

  // Response scoreboard: compares on the cycle the handshake is presented.
  always @(negedge clk) begin
    if (reset === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        fail_event("unexpected_rsp");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id",     64'(rsp_id),     64'(e.id));
        check("rsp_result", 64'(rsp_result), 64'(e.res));
        check("rsp_flags",  64'(rsp_flags),  64'(e.flags));
        check("rsp_err",    64'(rsp_err),    64'(e.err));
      end
    end
  end

  task automatic drive_req(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
    req_valid[id]                 = 1'b1;
    req_op1[int'(id)*32 +: 32]    = a;
    req_op2[int'(id)*32 +: 32]    = b;
    req_ctrl[int'(id)*4 +: 4]     = c;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        g = req_ready;
        break;
      end
    end
    if (g == 4'b0000) fail_event("grant_timeout");
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && busy == 1'b0) done = 1'b1;
    end
    if (!done) begin
      fail_event("drain_timeout");
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t       e;
    logic [3:0] g;
    e.id = v.id; e.res = v.res; e.flags = v.flags; e.err = v.err;
    sb.push_back(e);
    drive_req(v.id, v.op1, v.op2, v.ctrl);
    wait_grant(g);
    check("grant", 64'(g), 64'(4'b0001 << v.id));
    @(posedge clk);
    #1 req_valid[v.id] = 1'b0;
    @(negedge clk);
    check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    check("exec_busy",      64'(busy),      64'd1);
    check("exec_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("resp_rsp_valid", 64'(rsp_valid), 64'd1);
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    exp_t       e1;
    bit         seen;

    reset     = 1'b0;
    req_valid = 4'b1111;
    req_op1   = '0;
    req_op2   = '0;
    req_ctrl  = '0;
    rsp_ready = 1'b1;
    #1;
    check("rst_req_ready",  64'(req_ready),  64'd0);
    check("rst_rsp_valid",  64'(rsp_valid),  64'd0);
    check("rst_rsp_id",     64'(rsp_id),     64'd0);
    check("rst_rsp_result", 64'(rsp_result), 64'd0);
    check("rst_rsp_flags",  64'(rsp_flags),  64'd0);
    check("rst_rsp_err",    64'(rsp_err),    64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    #20 req_valid = 4'b0000;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: single request, flag corners, illegal opcodes, ctrl boundary.
    vecs.push_back(mk(2'd2, 32'd7,         32'd1,         ALU_ADD,  32'd8,         4'b0000, 1'b0));
    vecs.push_back(mk(2'd1, 32'd5,         32'd7,         ALU_SUB,  32'hFFFFFFFE, 4'b1010, 1'b0));
    vecs.push_back(mk(2'd0, 32'h7FFFFFFF, 32'd1,         ALU_ADD,  32'h80000000, 4'b1001, 1'b0));
    vecs.push_back(mk(2'd3, 32'hFFFFFFFF, 32'd1,         ALU_ADD,  32'd0,         4'b0110, 1'b0));
    vecs.push_back(mk(2'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 4'b1100,  32'd0,         4'b0000, 1'b1));
    vecs.push_back(mk(2'd1, 32'hF0F0F0F0, 32'hFF00FF00, ALU_AND,  32'hF000F000, 4'b1000, 1'b0));
    vecs.push_back(mk(2'd2, 32'd3,         32'd5,         ALU_SLT,  32'd1,         4'b0000, 1'b0));
    vecs.push_back(mk(2'd3, 32'hFFFFFFFF, 32'd1,         ALU_SLTU, 32'd0,         4'b0100, 1'b0));
    vecs.push_back(mk(2'd0, 32'd1,         32'd31,        ALU_SLL,  32'h80000000, 4'b1000, 1'b0));
    vecs.push_back(mk(2'd1, 32'd1,         32'd2,         4'b1010,  32'd0,         4'b0000, 1'b1));
    vecs.push_back(mk(2'd2, 32'd9,         32'd9,         ALU_SLTU, 32'd0,         4'b0100, 1'b0));
    vecs.push_back(mk(2'd3, 32'h80000000, 32'd4,         ALU_SRL,  32'h08000000, 4'b0000, 1'b0));
    vecs.push_back(mk(2'd0, 32'd0,         32'd0,         ALU_OR,   32'd0,         4'b0100, 1'b0));
    vecs.push_back(mk(2'd1, 32'hFFFF0000, 32'h0000FFFF, 4'b1111,  32'd0,         4'b0000, 1'b1));
    for (int k = 1; k <= 10; k++) begin
      logic [36:0] r;
      r = ref_alu(32'h80000000, 32'(k), ALU_SRA);
      vecs.push_back(mk(2'(k % 4), 32'h80000000, 32'(k), ALU_SRA, r[31:0], r[35:32], r[36]));
    end
    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-pressure: response held while rsp_ready is low, other requester waits.
    rsp_ready = 1'b0;
    e1 = exp_of(2'd1, 32'h12345678, 32'h0F0F0F0F, ALU_XOR);
    sb.push_back(e1);
    drive_req(2'd1, 32'h12345678, 32'h0F0F0F0F, ALU_XOR);
    wait_grant(g);
    check("bp_grant1", 64'(g), 64'(4'b0010));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    sb.push_back(exp_of(2'd3, 32'd58, 32'd100, ALU_SUB));
    drive_req(2'd3, 32'd58, 32'd100, ALU_SUB);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) fail_event("bp_rsp_timeout");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid",     64'(rsp_valid),  64'd1);
      check("bp_id",        64'(rsp_id),     64'(e1.id));
      check("bp_result",    64'(rsp_result), 64'(e1.res));
      check("bp_req_ready", 64'(req_ready),  64'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_req_ready_hs", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_released", 64'(rsp_valid), 64'd0);
    check("bp_grant3",   64'(req_ready), 64'(4'b1000));
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    wait_drain();

    // Reset asserted while the ALU operation is in EXEC.
    sb.push_back(exp_of(2'd2, 32'd1000, 32'd1, ALU_ADD));
    drive_req(2'd2, 32'd1000, 32'd1, ALU_ADD);
    wait_grant(g);
    check("rx_grant", 64'(g), 64'(4'b0100));
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    #2 reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    sb.delete();
    check("rx_req_ready",  64'(req_ready),  64'd0);
    check("rx_rsp_valid",  64'(rsp_valid),  64'd0);
    check("rx_rsp_id",     64'(rsp_id),     64'd0);
    check("rx_rsp_result", 64'(rsp_result), 64'd0);
    check("rx_rsp_flags",  64'(rsp_flags),  64'd0);
    check("rx_rsp_err",    64'(rsp_err),    64'd0);
    check("rx_busy",       64'(busy),       64'd0);
    req_valid = 4'b0000;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rx_no_rsp",  64'(rsp_valid), 64'd0);
      check("rx_idle",    64'(busy),      64'd0);
    end
    @(posedge clk);
    #1;

    // Saturation straight after reset: order 0,1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      drive_req(2'(i), 32'h11111111 * 32'(i + 1), 32'(i + 3), 4'(i));
    end
    for (int k = 0; k < 5; k++) begin
      sb.push_back(exp_of(2'(k % 4), 32'h11111111 * 32'((k % 4) + 1), 32'((k % 4) + 3),
                          4'(k % 4)));
    end
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check("sat_grant", 64'(g), 64'(4'b0001 << (k % 4)));
      @(posedge clk);
    end
    #1 req_valid = 4'b0000;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
